// File: rtl/dm_lsu.sv
// dm_lsu: MEM-stage load/store initiator for the word-only data memory dm.
// Sub-word stores are done as read-modify-write; bad requests get an error response and no access.
module dm_lsu #(
  parameter int unsigned DM_WORDS = 128
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [2:0]  i_req_funct3,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [31:0] i_req_inst,
  output logic        o_resp_valid,
  output logic        o_resp_err,
  output logic [31:0] o_resp_rdata,
  output logic        o_dm_wea,
  output logic [9:0]  o_dm_addra,
  output logic [31:0] o_dm_dina,
  input  logic [31:0] i_dm_douta,
  output logic [31:0] o_dm_inst
);

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {S_IDLE, S_ACCESS, S_WRITE, S_DONE, S_ERR} state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic            r_we;
  logic [2:0]      r_funct3;
  logic [1:0]      r_off;
  logic [DW-1:0]   r_wdata;
  logic [DW-1:0]   r_ld;
  logic [DW-1:0]   r_merge;
  logic            r_wea;
  logic [AW-1:0]   r_addra;
  logic [DW-1:0]   r_dina;
  logic [DW-1:0]   r_inst;
  logic            r_resp_valid;
  logic            r_resp_err;
  logic [DW-1:0]   r_resp_rdata;

  logic            w_accept;
  logic            w_f3_ok;
  logic            w_misaligned;
  logic            w_range_err;
  logic            w_req_err;
  logic [DW-1:0]   w_shifted;
  logic [DW-1:0]   w_ld_ext;
  logic [DW-1:0]   w_lane_mask;
  logic [DW-1:0]   w_lane_data;
  logic [DW-1:0]   w_merged;
  logic            w_ld_cap;
  logic            w_merge_cap;
  logic            w_wea_nxt;
  logic [DW-1:0]   w_dina_nxt;
  logic            w_resp_valid_nxt;
  logic            w_resp_err_nxt;
  logic [DW-1:0]   w_rdata_nxt;

  assign w_accept    = i_req_valid && (r_state == S_IDLE);
  assign o_req_ready = (r_state == S_IDLE);

  // Request legality, evaluated on the live request so the FSM can branch at accept
  always_comb begin
    w_f3_ok = 1'b0;
    case (i_req_funct3)
      F3_B, F3_H, F3_W: w_f3_ok = 1'b1;
      F3_BU, F3_HU:     w_f3_ok = !i_req_we;
      default:          w_f3_ok = 1'b0;
    endcase
    w_misaligned = ((i_req_funct3[1:0] == 2'b01) && i_req_addr[0]) ||
                   ((i_req_funct3[1:0] == 2'b10) && (i_req_addr[1:0] != 2'b00));
    w_range_err  = {2'b00, i_req_addr[31:2]} >= DM_WORDS;
    w_req_err    = !w_f3_ok || w_misaligned || w_range_err;
  end

  // Halfwords are 2-byte aligned, so a byte-granular shift also selects the half lane
  always_comb begin
    w_shifted = i_dm_douta >> {r_off, 3'b000};
    case (r_funct3)
      F3_B:    w_ld_ext = {{24{w_shifted[7]}}, w_shifted[7:0]};
      F3_BU:   w_ld_ext = {24'h000000, w_shifted[7:0]};
      F3_H:    w_ld_ext = {{16{w_shifted[15]}}, w_shifted[15:0]};
      F3_HU:   w_ld_ext = {16'h0000, w_shifted[15:0]};
      default: w_ld_ext = i_dm_douta;
    endcase
  end

  always_comb begin
    w_lane_mask = (r_funct3[0] ? 32'h0000FFFF : 32'h000000FF) << {r_off, 3'b000};
    w_lane_data = r_wdata << {r_off, 3'b000};
    w_merged    = (r_merge & ~w_lane_mask) | (w_lane_data & w_lane_mask);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_ld_cap         = 1'b0;
    w_merge_cap      = 1'b0;
    w_wea_nxt        = 1'b0;
    w_dina_nxt       = r_dina;
    w_resp_valid_nxt = 1'b0;
    w_resp_err_nxt   = 1'b0;
    w_rdata_nxt      = r_resp_rdata;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = w_req_err ? S_ERR : S_ACCESS;
      end
      S_ACCESS: begin
        if (!r_we) begin
          w_ld_cap    = 1'b1;
          w_state_nxt = S_DONE;
        end else if (r_funct3 == F3_W) begin
          w_wea_nxt   = 1'b1;
          w_dina_nxt  = r_wdata;
          w_state_nxt = S_DONE;
        end else begin
          w_merge_cap = 1'b1;
          w_state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        w_wea_nxt   = 1'b1;
        w_dina_nxt  = w_merged;
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_resp_valid_nxt = 1'b1;
        w_rdata_nxt      = r_we ? 32'h0 : r_ld;
        w_state_nxt      = S_IDLE;
      end
      S_ERR: begin
        w_resp_valid_nxt = 1'b1;
        w_resp_err_nxt   = 1'b1;
        w_rdata_nxt      = 32'h0;
        w_state_nxt      = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request latch, capture registers and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_we         <= 1'b0;
      r_funct3     <= 3'b000;
      r_off        <= 2'b00;
      r_wdata      <= '0;
      r_ld         <= '0;
      r_merge      <= '0;
      r_wea        <= 1'b0;
      r_addra      <= '0;
      r_dina       <= '0;
      r_inst       <= '0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_we     <= i_req_we;
        r_funct3 <= i_req_funct3;
        r_off    <= i_req_addr[1:0];
        r_wdata  <= i_req_wdata;
        r_addra  <= i_req_addr[11:2];
        r_inst   <= i_req_inst;
      end
      if (w_ld_cap)    r_ld    <= w_ld_ext;
      if (w_merge_cap) r_merge <= i_dm_douta;
      r_wea        <= w_wea_nxt;
      r_dina       <= w_dina_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_resp_err   <= w_resp_err_nxt;
      r_resp_rdata <= w_rdata_nxt;
    end
  end

  // Gated by rst so that no write can land in a reset cycle
  assign o_dm_wea     = r_wea && !i_rst;
  assign o_dm_addra   = r_addra;
  assign o_dm_dina    = r_dina;
  assign o_dm_inst    = r_inst;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_err   = r_resp_err;
  assign o_resp_rdata = r_resp_rdata;

endmodule

// File: tb/tb_dm_lsu.sv
// tb_dm_lsu: randomized scoreboard bench for dm_lsu with a word-memory model and a byte-level reference.
module tb_dm_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [31:0] req_inst = 32'h0;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        dm_wea;
  logic [9:0]  dm_addra;
  logic [31:0] dm_dina;
  logic [31:0] dm_douta;
  logic [31:0] dm_inst;

  logic [31:0] mem [0:1023];
  logic [31:0] ref_mem [0:127];
  logic        poke_en = 1'b0;
  logic [9:0]  poke_a = 10'h0;
  logic [31:0] poke_d = 32'h0;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  typedef struct { logic err; logic [31:0] rdata; int acc; int lat; } rexp_t;
  typedef struct { logic [9:0] a; logic [31:0] d; int cyc; } wexp_t;
  rexp_t rq[$];
  wexp_t wq[$];

  always #5 clk = ~clk;

  dm_lsu #(.DM_WORDS(128)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_we(req_we), .i_req_funct3(req_funct3), .i_req_addr(req_addr),
    .i_req_wdata(req_wdata), .i_req_inst(req_inst), .o_resp_valid(resp_valid),
    .o_resp_err(resp_err), .o_resp_rdata(resp_rdata), .o_dm_wea(dm_wea),
    .o_dm_addra(dm_addra), .o_dm_dina(dm_dina), .i_dm_douta(dm_douta), .o_dm_inst(dm_inst)
  );

  // Word memory: synchronous write, asynchronous read
  always @(posedge clk) begin
    if (poke_en)     mem[poke_a] <= poke_d;
    else if (dm_wea) mem[dm_addra] <= dm_dina;
  end
  assign dm_douta = mem[dm_addra];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboards whenever the DUT responds or writes
  initial forever begin
    rexp_t e;
    wexp_t w;
    @(negedge clk);
    if (resp_valid === 1'b1) begin
      if (rq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_resp: got resp_valid=1 expected none (cycle %0d)", cyc);
      end else begin
        e = rq.pop_front();
        chk("resp_err", {31'h0, resp_err}, {31'h0, e.err});
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_latency", 32'(cyc - e.acc), 32'(e.lat));
      end
    end
    if (dm_wea === 1'b1) begin
      if (wq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: got write addr %h data %h expected none", dm_addra, dm_dina);
      end else begin
        w = wq.pop_front();
        chk("write_addr", {22'h0, dm_addra}, {22'h0, w.a});
        chk("write_data", dm_dina, w.d);
        chk("write_cycle", 32'(cyc), 32'(w.cyc));
      end
    end
  end

  function automatic logic model_err(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    logic ok;
    case (f3)
      3'd0, 3'd1, 3'd2: ok = 1'b1;
      3'd4, 3'd5:       ok = !we;
      default:          ok = 1'b0;
    endcase
    if (!ok) return 1'b1;
    if ((f3 == 3'd1 || f3 == 3'd5) && (addr % 2) != 0) return 1'b1;
    if (f3 == 3'd2 && (addr % 4) != 0) return 1'b1;
    if (addr / 4 >= 128) return 1'b1;
    return 1'b0;
  endfunction

  // Reference: byte-array view of the addressed word; mode 1 overrides load data with a constant
  task automatic model_push(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd, input int acc, input int mode, input logic [31:0] k);
    rexp_t e;
    wexp_t w;
    logic [7:0] by [4];
    logic [31:0] word;
    int off, idx;
    off = int'(addr % 4);
    idx = int'(addr / 4);
    e.acc = acc;
    e.err = model_err(we, f3, addr);
    e.rdata = 32'h0;
    e.lat = e.err ? 1 : 2;
    if (!e.err) begin
      word = ref_mem[idx];
      for (int i = 0; i < 4; i++) by[i] = word[8*i +: 8];
      if (!we) begin
        case (f3)
          3'd0:    e.rdata = {{24{by[off][7]}}, by[off]};
          3'd4:    e.rdata = {24'h0, by[off]};
          3'd1:    e.rdata = {{16{by[off+1][7]}}, by[off+1], by[off]};
          3'd5:    e.rdata = {16'h0, by[off+1], by[off]};
          default: e.rdata = word;
        endcase
        if (mode == 1) e.rdata = k;
      end else begin
        if (f3 == 3'd2) begin
          for (int i = 0; i < 4; i++) by[i] = wd[8*i +: 8];
        end else begin
          by[off] = wd[7:0];
          if (f3 == 3'd1) by[off+1] = wd[15:8];
          e.lat = 3;
        end
        word = {by[3], by[2], by[1], by[0]};
        ref_mem[idx] = word;
        w.a = 10'(idx);
        w.d = word;
        w.cyc = acc + ((f3 == 3'd2) ? 1 : 2);
        wq.push_back(w);
      end
    end
    rq.push_back(e);
  endtask

  // mode 0: model, 1: constant load result, 2: abandoned (no expectation)
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input int mode, input logic [31:0] k);
    int n;
    logic [31:0] inst;
    n = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (req_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL ready_timeout: got req_ready=%b expected 1 within 20 cycles", req_ready);
      return;
    end
    inst = $urandom;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_inst = inst;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_inst = $urandom;
    chk("dm_inst", dm_inst, inst);
    if (mode != 2) model_push(we, f3, addr, wd, cyc, mode, k);
  endtask

  task automatic poke(input int idx, input logic [31:0] val);
    poke_en = 1'b1; poke_a = 10'(idx); poke_d = val;
    @(posedge clk);
    #1;
    poke_en = 1'b0;
    ref_mem[idx] = val;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((rq.size() != 0 || wq.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (rq.size() != 0 || wq.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d resp and %0d writes pending expected 0", rq.size(), wq.size());
      rq.delete();
      wq.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int bad;
    logic [31:0] a;
    int c0;

    // Reset held two cycles; outputs checked while rst is still high
    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_resp_err", {31'h0, resp_err}, 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_dm_addra", {22'h0, dm_addra}, 32'h0);
    chk("rst_dm_dina", dm_dina, 32'h0);
    chk("rst_dm_inst", dm_inst, 32'h0);
    chk("rst_dm_wea", {31'h0, dm_wea}, 32'h0);
    chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
    rst = 1'b0;

    for (int i = 0; i < 128; i++) poke(i, $urandom);
    poke(1, 32'h80FF7F01);
    poke(2, 32'h11223344);

    // Load extraction against fixed expectations
    issue(1'b0, 3'd0, 32'h4, 32'h0, 1, 32'h00000001);
    issue(1'b0, 3'd0, 32'h5, 32'h0, 1, 32'h0000007F);
    issue(1'b0, 3'd0, 32'h6, 32'h0, 1, 32'hFFFFFFFF);
    issue(1'b0, 3'd0, 32'h7, 32'h0, 1, 32'hFFFFFF80);
    issue(1'b0, 3'd5, 32'h6, 32'h0, 1, 32'h000080FF);
    issue(1'b0, 3'd1, 32'h6, 32'h0, 1, 32'hFFFF80FF);
    // RMW stores, word store/load, then the rejected requests
    issue(1'b1, 3'd0, 32'h9, 32'h000000AB, 0, 32'h0);
    issue(1'b1, 3'd1, 32'hA, 32'h0000BEEF, 0, 32'h0);
    issue(1'b1, 3'd2, 32'hC, 32'hDEADBEEF, 0, 32'h0);
    issue(1'b0, 3'd2, 32'hC, 32'h0, 1, 32'hDEADBEEF);
    issue(1'b0, 3'd2, 32'h2, 32'h0, 0, 32'h0);
    issue(1'b1, 3'd1, 32'h1, 32'h1234, 0, 32'h0);
    issue(1'b1, 3'd4, 32'h10, 32'h55, 0, 32'h0);
    issue(1'b0, 3'd2, 32'h200, 32'h0, 0, 32'h0);
    drain();
    chk("mem_word2", mem[2], 32'hBEEFAB44);
    chk("mem_word3", mem[3], 32'hDEADBEEF);

    // sb abandoned by reset during its WRITE cycle
    issue(1'b1, 3'd0, 32'h21, 32'h5A, 2, 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("abandoned_word", mem[8], ref_mem[8]);

    // Request held valid while busy is taken only once back in IDLE (3 edges later)
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h4; req_inst = $urandom;
    @(posedge clk);
    #1;
    c0 = cyc;
    model_push(1'b0, 3'd2, 32'h4, 32'h0, c0, 0, 32'h0);
    req_funct3 = 3'd4; req_addr = 32'h7;
    model_push(1'b0, 3'd4, 32'h7, 32'h0, c0 + 3, 0, 32'h0);
    repeat (3) @(posedge clk);
    #1 req_valid = 1'b0;
    drain();

    // Random traffic, mostly in range with occasional wild addresses
    for (int i = 0; i < 300; i++) begin
      a = ($urandom % 10 == 0) ? $urandom : 32'($urandom_range(0, 'h21F));
      issue(1'($urandom), 3'($urandom), a, $urandom, 0, 32'h0);
      if ($urandom % 4 == 0) @(negedge clk);
    end
    drain();

    bad = 0;
    for (int i = 0; i < 128; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk("final_mem_mismatches", 32'(bad), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
